// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants, types and colour palette for VGA scan-out
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int READ_LAT = 1;
  typedef logic [2:0]  color_code_t;
  typedef logic [11:0] rgb12_t;
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
    logic first;
  } ctl_t;
  localparam ctl_t CTL_IDLE = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1, first: 1'b0};
  function automatic rgb12_t palette(input color_code_t c);
    case (c)
      3'd0:    palette = 12'h000;
      3'd1:    palette = 12'hF00;
      3'd2:    palette = 12'h0F0;
      3'd3:    palette = 12'h00F;
      3'd4:    palette = 12'hFF0;
      3'd5:    palette = 12'h0FF;
      3'd6:    palette = 12'hF0F;
      default: palette = 12'hFFF;
    endcase
  endfunction
endpackage

// File: rtl/vga_timing.sv
// vga_timing: raster counters, active window, raw (undelayed) syncs and first-pixel flag
module vga_timing
  import vga_pkg::*;
#(
  parameter int HA = H_ACTIVE,
  parameter int HF = H_FP,
  parameter int HS = H_SYNC,
  parameter int HB = H_BP,
  parameter int VA = V_ACTIVE,
  parameter int VF = V_FP,
  parameter int VS = V_SYNC,
  parameter int VB = V_BP
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] o_hcnt,
  output logic [9:0] o_vcnt,
  output ctl_t       o_ctl
);
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  logic [9:0] r_hcnt, r_vcnt;
  logic       w_eol;
  assign w_eol = r_hcnt == 10'(HT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else begin
      r_hcnt <= w_eol ? '0 : r_hcnt + 10'd1;
      if (w_eol) r_vcnt <= r_vcnt == 10'(VT - 1) ? '0 : r_vcnt + 10'd1;
    end
  assign o_hcnt       = r_hcnt;
  assign o_vcnt       = r_vcnt;
  assign o_ctl.active = r_hcnt < 10'(HA) && r_vcnt < 10'(VA);
  assign o_ctl.hsync  = !(r_hcnt >= 10'(HA + HF) && r_hcnt < 10'(HA + HF + HS));
  assign o_ctl.vsync  = !(r_vcnt >= 10'(VA + VF) && r_vcnt < 10'(VA + VF + VS));
  assign o_ctl.first  = r_hcnt == '0 && r_vcnt == '0;
endmodule

// File: rtl/vga_scan_out.sv
// vga_scan_out: raster scan-out; drives store read addresses, palettes the returned
// colour code and delays sync/blank so everything reaches the pins aligned.
module vga_scan_out
  import vga_pkg::*;
#(
  parameter int HA = H_ACTIVE,
  parameter int HF = H_FP,
  parameter int HS = H_SYNC,
  parameter int HB = H_BP,
  parameter int VA = V_ACTIVE,
  parameter int VF = V_FP,
  parameter int VS = V_SYNC,
  parameter int VB = V_BP
) (
  input  logic        clk,
  input  logic        reset,
  input  color_code_t colorCode,
  output logic [9:0]  rx,
  output logic [9:0]  ry,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        frameStart
);
  logic [9:0]               w_hcnt, w_vcnt;
  ctl_t                     w_ctl;
  ctl_t [READ_LAT-1:0]      r_dly;
  rgb12_t                   r_rgb;
  logic                     r_hsync, r_vsync, r_frame;
  vga_timing #(
    .HA(HA), .HF(HF), .HS(HS), .HB(HB),
    .VA(VA), .VF(VF), .VS(VS), .VB(VB)
  ) u_timing (
    .clk    (clk),
    .rst    (reset),
    .o_hcnt (w_hcnt),
    .o_vcnt (w_vcnt),
    .o_ctl  (w_ctl)
  );
  assign rx = w_ctl.active ? w_hcnt : '0;
  assign ry = w_ctl.active ? w_vcnt : '0;
  // control bits ride alongside the store read so they meet colorCode in the same cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_dly   <= {READ_LAT{CTL_IDLE}};
      r_rgb   <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_frame <= 1'b0;
    end else begin
      r_dly[0] <= w_ctl;
      for (int i = 1; i < READ_LAT; i++) r_dly[i] <= r_dly[i-1];
      r_rgb   <= r_dly[READ_LAT-1].active ? palette(colorCode) : '0;
      r_hsync <= r_dly[READ_LAT-1].hsync;
      r_vsync <= r_dly[READ_LAT-1].vsync;
      r_frame <= r_dly[READ_LAT-1].first;
    end
  assign red        = r_rgb[11:8];
  assign green      = r_rgb[7:4];
  assign blue       = r_rgb[3:0];
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign frameStart = r_frame;
endmodule

// File: tb/tb_vga_scan_out.sv
// tb_vga_scan_out: full-size and shrunken-timing scan-out instances checked every pixel
// clock against an arithmetic raster model fed by a 1-clk-latency pixel store model.
module tb_vga_scan_out;
  typedef struct packed {int ha, hf, hs, hb, va, vf, vs, vb;} tim_t;
  localparam tim_t TA = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam tim_t TB = '{16, 2, 3, 3, 8, 2, 2, 2};
  logic        clk = 1'b0, reset = 1'b1;
  logic [2:0]  cc_a = '0, cc_b = '0;
  logic [9:0]  a_rx, a_ry, b_rx, b_ry, pa_rx = '0, pb_rx = '0;
  logic        a_hs, a_vs, a_fs, b_hs, b_vs, b_fs;
  logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b;
  logic [11:0] pal [8] = '{12'h000, 12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF};
  int n_cmp = 0, n_err = 0;
  int n = 0, mode = 0, hs_low = 0, first_low = -1, last_fs = -1;
  always #20 clk = ~clk;
  vga_scan_out u_dut_a (
    .clk(clk), .reset(reset), .colorCode(cc_a), .rx(a_rx), .ry(a_ry),
    .hsync(a_hs), .vsync(a_vs), .red(a_r), .green(a_g), .blue(a_b), .frameStart(a_fs)
  );
  vga_scan_out #(
    .HA(16), .HF(2), .HS(3), .HB(3), .VA(8), .VF(2), .VS(2), .VB(2)
  ) u_dut_b (
    .clk(clk), .reset(reset), .colorCode(cc_b), .rx(b_rx), .ry(b_ry),
    .hsync(b_hs), .vsync(b_vs), .red(b_r), .green(b_g), .blue(b_b), .frameStart(b_fs)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at n=%0d: got %0h, expected %0h", tag, n, got, exp);
    end
  endtask
  // n = pixel clocks since reset release; pins show pixel n-2, addresses show pixel n
  task automatic check_dut(input string nm, input tim_t t, input int k, input logic [2:0] code,
                           input logic [9:0] orx, input logic [9:0] ory, input logic ohs,
                           input logic ovs, input logic ofs, input logic [11:0] orgb);
    int ht = t.ha + t.hf + t.hs + t.hb;
    int vt = t.va + t.vf + t.vs + t.vb;
    int h = k % ht;
    int v = (k / ht) % vt;
    bit act = h < t.ha && v < t.va;
    check({nm, ".rx"}, 32'(orx), act ? h : 0);
    check({nm, ".ry"}, 32'(ory), act ? v : 0);
    if (k < 2) begin
      check({nm, ".hsync_idle"}, 32'(ohs), 1);
      check({nm, ".vsync_idle"}, 32'(ovs), 1);
      check({nm, ".fs_idle"}, 32'(ofs), 0);
      check({nm, ".rgb_idle"}, 32'(orgb), 0);
    end else begin
      h = (k - 2) % ht;
      v = ((k - 2) / ht) % vt;
      act = h < t.ha && v < t.va;
      check({nm, ".hsync"}, 32'(ohs), (h >= t.ha + t.hf && h < t.ha + t.hf + t.hs) ? 0 : 1);
      check({nm, ".vsync"}, 32'(ovs), (v >= t.va + t.vf && v < t.va + t.vf + t.vs) ? 0 : 1);
      check({nm, ".frameStart"}, 32'(ofs), (h == 0 && v == 0) ? 1 : 0);
      check({nm, ".rgb"}, 32'(orgb), act ? 32'(pal[code]) : 0);
    end
  endtask
  task automatic check_now();
    check_dut("a", TA, n, cc_a, a_rx, a_ry, a_hs, a_vs, a_fs, {a_r, a_g, a_b});
    check_dut("b", TB, n, cc_b, b_rx, b_ry, b_hs, b_vs, b_fs, {b_r, b_g, b_b});
  endtask
  task automatic step();
    @(negedge clk);
    if (!reset) n++;
    check_now();
    if (n >= 2 && n < 802 && !a_hs) begin
      hs_low++;
      if (first_low < 0) first_low = n;
    end
    if (b_fs) begin
      if (last_fs >= 0) check("b.fs_period", n - last_fs, 336);
      last_fs = n;
    end
    cc_a = mode == 0 ? pa_rx[2:0] : mode == 1 ? 3'd7 : 3'($urandom);
    cc_b = mode == 0 ? pb_rx[2:0] : mode == 1 ? 3'd7 : 3'($urandom);
    pa_rx = a_rx;
    pb_rx = b_rx;
  endtask
  task automatic pulse_reset(input int len);
    #2 reset = 1'b1;
    n = 0;
    last_fs = -1;
    #1 check_now();
    repeat (len) step();
    reset = 1'b0;
  endtask
  initial begin
    repeat (5) step();
    reset = 1'b0;
    mode = 0;
    repeat (1200) step();
    check("a.hs_low_len", hs_low, 96);
    check("a.hs_first_low", first_low, 658);
    mode = 1;
    repeat (3000) step();
    mode = 2;
    repeat (20000) step();
    pulse_reset(1);
    mode = 0;
    repeat (1500) step();
    mode = 2;
    repeat (($urandom % 700) + 300) step();
    pulse_reset(($urandom % 4) + 1);
    mode = 1;
    repeat (2500) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
